game_flow_fsm: RTL and testbench
================================

Name: game_flow_fsm

Overview:
Parametrised top-level game-flow controller for the Super Hexagon design. Sequences start screen, play, pause, death animation and game over, and tracks the selected difficulty mode with optional automatic promotion. Tracks survival time in frames and a best-time record for the display path. Inputs come from the keyboard decoder, the collision detector and the VGA frame tick.

Parameters:
NUM_MODES, 3, number of difficulty modes (2..8); MODE_W = max(1, clog2(NUM_MODES)) is derived
MODE_KEY_BASE, 8'd30, keycode selecting mode 0; mode i uses MODE_KEY_BASE+i
RESTART_KEY, 8'h28, keycode that returns to start screen
PAUSE_KEY, 8'h13, keycode that toggles pause
DEATH_HOLD_FRAMES, 60, frame ticks spent in DYING before GAME_OVER (>=1)
LEVEL_UP_FRAMES, 600, frame ticks in one mode before auto-promotion
AUTO_PROMOTE, 1, 1 enables automatic mode promotion
TIME_W, 16, width of survival/best counters

Ports:
Clk  in  1  system clock; single clock domain
Reset_h  in  1  reset, synchronous, active-high
keycode  in  8  current keyboard keycode; 0 = no key
is_collision  in  1  player/wall collision, level-sensitive
frame_tick  in  1  one-cycle pulse per video frame
Current_State  out  3  START=0, PLAY=1, PAUSE=2, DYING=3, GAME_OVER=4
Mode  out  MODE_W  active difficulty mode
survive_frames  out  TIME_W  frames survived this run
best_frames  out  TIME_W  best survive_frames since reset
level_up  out  1  one-cycle pulse on auto-promotion
game_over_pulse  out  1  one-cycle pulse on DYING->GAME_OVER

Behaviour:
- Reset (sync, Reset_h=1 at Clk edge): State=START, Mode=0, survive_frames=0, best_frames=0, level counter=0, death counter=0, key_q=0, pulses=0. Reset mid-game aborts immediately.
- All outputs are registered. A transition decided in cycle n shows on Current_State in cycle n+1.
- Key press = keycode!=0 && keycode!=key_q. key_q<=keycode every cycle. Holding a key gives one press. A key held through reset counts as one press after reset.
- START: press of MODE_KEY_BASE+i with i<NUM_MODES -> PLAY, Mode<=i, survive_frames<=0, level counter<=0. Other keys, collision and ticks are ignored.
- PLAY:
  - frame_tick: survive_frames+1, saturating at all-ones; level counter+1.
  - is_collision=1 -> DYING. The tick in the same cycle still counts.
  - Else PAUSE_KEY press -> PAUSE.
  - Collision has priority over pause and promotion.
- Auto-promotion (PLAY, AUTO_PROMOTE=1, no collision):
  - Triggers when the level counter reaches LEVEL_UP_FRAMES on a tick.
  - If Mode<NUM_MODES-1: Mode+1, level_up=1 for one cycle, level counter<=0.
  - At top mode: no pulse; level counter saturates.
- PAUSE: counters frozen; collision and ticks ignored. PAUSE_KEY press -> PLAY. RESTART_KEY press -> START, with Mode and survive_frames held.
- DYING: death counter cleared on entry and counts ticks. On the DEATH_HOLD_FRAMES-th tick -> GAME_OVER, game_over_pulse=1 for one cycle, and best_frames<=max(best_frames, survive_frames). Keys are ignored.
- GAME_OVER: all values held for display. RESTART_KEY press -> START. Other keys are ignored.
- Unused state encodings (5-7) -> START next cycle.
- level_up and game_over_pulse are never high in the same cycle.

Test Plan:
- Reset, then keycode 30 for 3 cycles then 0 -> one transition to PLAY, Mode=0; Current_State=1 one cycle after the press.
- NUM_MODES=3: keycode 33 in START -> stays START; keycode 32 -> PLAY with Mode=2.
- PLAY, 10 ticks, PAUSE_KEY press, 5 ticks, PAUSE_KEY press -> survive_frames=10 after the pause; PAUSE then PLAY.
- LEVEL_UP_FRAMES=4, Mode=0, 8 ticks -> level_up pulses on tick 4 and tick 8, Mode=2. Another 4 ticks -> no pulse, Mode=2.
- Collision and PAUSE_KEY press and a tick in the same cycle -> DYING, survive_frames incremented.
- DEATH_HOLD_FRAMES=3, run with 20 ticks then collision -> GAME_OVER after 3 ticks, game_over_pulse once, best_frames=20. Second run of 12 -> best_frames stays 20. Reset mid-DYING -> START, best_frames=0.

Source files
------------

// File: rtl/game_flow_if.sv
// ---------------------------------------------------------------------------
// game_flow_if
// Bundles the game-flow controller's signals: keyboard keycode, collision
// flag and frame tick coming in; state, mode, survival/best timers and the
// two event pulses going out to the display path.
//   master : keyboard / collision / video side (drives the inputs)
//   slave  : game_flow_fsm (drives the status outputs)
// Parameters must match the controller instance (NUM_MODES, TIME_W).
// ---------------------------------------------------------------------------
interface game_flow_if #(
    parameter int NUM_MODES = 3,
    parameter int TIME_W    = 16
);
    localparam int MODE_W = ($clog2(NUM_MODES) > 1) ? $clog2(NUM_MODES) : 1;

    logic [7:0]        keycode;
    logic              is_collision;
    logic              frame_tick;
    logic [2:0]        Current_State;
    logic [MODE_W-1:0] Mode;
    logic [TIME_W-1:0] survive_frames;
    logic [TIME_W-1:0] best_frames;
    logic              level_up;
    logic              game_over_pulse;

    modport master (
        output keycode, is_collision, frame_tick,
        input  Current_State, Mode, survive_frames, best_frames,
               level_up, game_over_pulse
    );

    modport slave (
        input  keycode, is_collision, frame_tick,
        output Current_State, Mode, survive_frames, best_frames,
               level_up, game_over_pulse
    );
endinterface

// File: rtl/game_flow_fsm.sv
// ---------------------------------------------------------------------------
// game_flow_fsm
// Top-level game-flow controller: START -> PLAY <-> PAUSE, PLAY -> DYING ->
// GAME_OVER -> START. Tracks the difficulty mode (with optional automatic
// promotion after LEVEL_UP_FRAMES ticks in one mode), frames survived in the
// current run and the best run since reset. Every output is a register.
// Ports:
//   Clk      : system clock
//   Reset_h  : synchronous active-high reset
//   bus      : game_flow_if.slave (keycode, is_collision, frame_tick in;
//              Current_State, Mode, survive_frames, best_frames, level_up,
//              game_over_pulse out)
// ---------------------------------------------------------------------------
module game_flow_fsm #(
    parameter int         NUM_MODES         = 3,
    parameter logic [7:0] MODE_KEY_BASE     = 8'd30,
    parameter logic [7:0] RESTART_KEY       = 8'h28,
    parameter logic [7:0] PAUSE_KEY         = 8'h13,
    parameter int         DEATH_HOLD_FRAMES = 60,
    parameter int         LEVEL_UP_FRAMES   = 600,
    parameter int         AUTO_PROMOTE      = 1,
    parameter int         TIME_W            = 16
) (
    input  logic         Clk,
    input  logic         Reset_h,
    game_flow_if.slave   bus
);
    localparam int MODE_W = ($clog2(NUM_MODES) > 1) ? $clog2(NUM_MODES) : 1;
    localparam int LVL_W  = $clog2(LEVEL_UP_FRAMES + 1);
    localparam int DTH_W  = ($clog2(DEATH_HOLD_FRAMES + 1) > 1) ? $clog2(DEATH_HOLD_FRAMES + 1) : 1;

    localparam logic [LVL_W-1:0]  LVL_MAX      = LVL_W'(LEVEL_UP_FRAMES);
    localparam logic [DTH_W-1:0]  DTH_LAST     = DTH_W'(DEATH_HOLD_FRAMES - 1);
    localparam logic [MODE_W-1:0] MODE_TOP     = MODE_W'(NUM_MODES - 1);
    localparam logic [TIME_W-1:0] TIME_MAX     = '1;
    localparam logic [8:0]        MODE_KEY_END = 9'(MODE_KEY_BASE) + 9'(NUM_MODES);

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_PLAY      = 3'd1,
        ST_PAUSE     = 3'd2,
        ST_DYING     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    state_e            state_q;
    logic [MODE_W-1:0] mode_q;
    logic [TIME_W-1:0] survive_q;
    logic [TIME_W-1:0] best_q;
    logic [LVL_W-1:0]  level_cnt_q;
    logic [DTH_W-1:0]  death_cnt_q;
    logic [7:0]        key_q;
    logic              level_up_q;
    logic              game_over_q;

    // Edge detect on the keycode: a held key is a single press, and because
    // key_q clears on reset a key held through reset yields one press after.
    logic key_press;
    assign key_press = (bus.keycode != 8'd0) && (bus.keycode != key_q);

    logic              mode_hit;
    logic [MODE_W-1:0] mode_sel;
    assign mode_hit = key_press && (bus.keycode >= MODE_KEY_BASE) &&
                      ({1'b0, bus.keycode} < MODE_KEY_END);
    assign mode_sel = MODE_W'(bus.keycode - MODE_KEY_BASE);

    logic pause_press, restart_press;
    assign pause_press   = key_press && (bus.keycode == PAUSE_KEY);
    assign restart_press = key_press && (bus.keycode == RESTART_KEY);

    // Saturating next values used on a frame tick in PLAY.
    logic [TIME_W-1:0] survive_inc_d;
    logic [LVL_W-1:0]  level_inc_d;
    assign survive_inc_d = (survive_q == TIME_MAX) ? survive_q : survive_q + TIME_W'(1);
    assign level_inc_d   = (level_cnt_q == LVL_MAX) ? LVL_MAX : level_cnt_q + LVL_W'(1);

    logic promote;
    assign promote = (AUTO_PROMOTE != 0) && bus.frame_tick && !bus.is_collision &&
                     (level_inc_d == LVL_MAX) && (mode_q != MODE_TOP);

    // NOTE: all state lives in this one clocked block and uses non-blocking
    // assignments, so later statements see the pre-edge values of every
    // register and the order of assignments inside a branch only decides
    // which write wins, never what is read.
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state_q     <= ST_START;
            mode_q      <= '0;
            survive_q   <= '0;
            best_q      <= '0;
            level_cnt_q <= '0;
            death_cnt_q <= '0;
            key_q       <= 8'd0;
            level_up_q  <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            key_q       <= bus.keycode;
            // Pulses default low so they last exactly one cycle.
            level_up_q  <= 1'b0;
            game_over_q <= 1'b0;

            case (state_q)
                ST_START: begin
                    if (mode_hit) begin
                        state_q     <= ST_PLAY;
                        mode_q      <= mode_sel;
                        survive_q   <= '0;
                        level_cnt_q <= '0;
                    end
                end

                ST_PLAY: begin
                    // A tick coinciding with a collision still counts.
                    if (bus.frame_tick) begin
                        survive_q   <= survive_inc_d;
                        level_cnt_q <= level_inc_d;
                    end
                    if (bus.is_collision) begin
                        state_q     <= ST_DYING;
                        death_cnt_q <= '0;
                    end else begin
                        if (promote) begin
                            mode_q      <= mode_q + MODE_W'(1);
                            level_up_q  <= 1'b1;
                            level_cnt_q <= '0;
                        end
                        if (pause_press) begin
                            state_q <= ST_PAUSE;
                        end
                    end
                end

                ST_PAUSE: begin
                    if (pause_press) begin
                        state_q <= ST_PLAY;
                    end else if (restart_press) begin
                        state_q <= ST_START;
                    end
                end

                ST_DYING: begin
                    if (bus.frame_tick) begin
                        if (death_cnt_q == DTH_LAST) begin
                            state_q     <= ST_GAME_OVER;
                            game_over_q <= 1'b1;
                            if (survive_q > best_q) begin
                                best_q <= survive_q;
                            end
                        end else begin
                            death_cnt_q <= death_cnt_q + DTH_W'(1);
                        end
                    end
                end

                ST_GAME_OVER: begin
                    if (restart_press) begin
                        state_q <= ST_START;
                    end
                end

                // Encodings 5..7 recover to the start screen.
                default: state_q <= ST_START;
            endcase
        end
    end

    assign bus.Current_State   = state_q;
    assign bus.Mode            = mode_q;
    assign bus.survive_frames  = survive_q;
    assign bus.best_frames     = best_q;
    assign bus.level_up        = level_up_q;
    assign bus.game_over_pulse = game_over_q;

endmodule

// File: tb/tb_game_flow_fsm.sv
// ---------------------------------------------------------------------------
// tb_game_flow_fsm
// Directed bench for game_flow_fsm with NUM_MODES=3, LEVEL_UP_FRAMES=4 and
// DEATH_HOLD_FRAMES=3. Inputs change 1 ns after a rising edge and outputs
// are sampled at the same point, after the edge that consumed the inputs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_game_flow_fsm;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    game_flow_if #(.NUM_MODES(3), .TIME_W(16)) bus ();

    game_flow_fsm #(
        .NUM_MODES        (3),
        .MODE_KEY_BASE    (8'd30),
        .RESTART_KEY      (8'h28),
        .PAUSE_KEY        (8'h13),
        .DEATH_HOLD_FRAMES(3),
        .LEVEL_UP_FRAMES  (4),
        .AUTO_PROMOTE     (1),
        .TIME_W           (16)
    ) dut (
        .Clk    (clk),
        .Reset_h(rst),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            cyc();
            bus.frame_tick = 1'b0;
        end
    endtask

    function automatic logic [31:0] st();
        return 32'(bus.Current_State);
    endfunction

    function automatic logic [31:0] md();
        return 32'(bus.Mode);
    endfunction

    function automatic logic [31:0] sv();
        return 32'(bus.survive_frames);
    endfunction

    function automatic logic [31:0] bs();
        return 32'(bus.best_frames);
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst              = 1'b1;
        bus.keycode      = 8'd0;
        bus.is_collision = 1'b0;
        bus.frame_tick   = 1'b0;
        cyc();
        cyc();
        check("rst_state",   st(), 32'd0);
        check("rst_mode",    md(), 32'd0);
        check("rst_survive", sv(), 32'd0);
        check("rst_best",    bs(), 32'd0);
        check("rst_lvlup",   32'(bus.level_up), 32'd0);
        check("rst_gop",     32'(bus.game_over_pulse), 32'd0);
        rst = 1'b0;

        // Keycode 33 is mode 3, outside NUM_MODES=3.
        bus.keycode = 8'd33; cyc();
        check("start_bad_key", st(), 32'd0);
        bus.keycode = 8'd0; cyc();

        // Key 30 held for three cycles: one start, Mode 0.
        bus.keycode = 8'd30; cyc();
        check("start_play_state", st(), 32'd1);
        check("start_play_mode",  md(), 32'd0);
        cyc(); cyc();
        bus.keycode = 8'd0; cyc();
        check("play_held_state",   st(), 32'd1);
        check("play_init_survive", sv(), 32'd0);

        // Promotion every 4 ticks until the top mode.
        tick(3);
        check("t3_survive", sv(), 32'd3);
        check("t3_lvlup",   32'(bus.level_up), 32'd0);
        tick(1);
        check("t4_lvlup", 32'(bus.level_up), 32'd1);
        check("t4_mode",  md(), 32'd1);
        tick(3);
        check("t7_lvlup", 32'(bus.level_up), 32'd0);
        check("t7_mode",  md(), 32'd1);
        tick(1);
        check("t8_lvlup",   32'(bus.level_up), 32'd1);
        check("t8_mode",    md(), 32'd2);
        check("t8_survive", sv(), 32'd8);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("top_no_lvlup", 32'(bus.level_up), 32'd0);
        end
        check("t12_mode",    md(), 32'd2);
        check("t12_survive", sv(), 32'd12);

        // Pause: held key and ticks have no effect; second press resumes.
        bus.keycode = 8'h13; cyc();
        check("pause_state", st(), 32'd2);
        tick(5);
        check("pause_hold_state",   st(), 32'd2);
        check("pause_frozen_count", sv(), 32'd12);
        bus.keycode = 8'd0; cyc();
        bus.keycode = 8'h13; cyc();
        check("resume_state",   st(), 32'd1);
        check("resume_survive", sv(), 32'd12);
        bus.keycode = 8'd0; cyc();

        // Collision, pause press and tick together: collision wins, tick counts.
        bus.keycode = 8'h13; bus.is_collision = 1'b1; bus.frame_tick = 1'b1;
        cyc();
        bus.keycode = 8'd0; bus.is_collision = 1'b0; bus.frame_tick = 1'b0;
        check("coll_state",   st(), 32'd3);
        check("coll_survive", sv(), 32'd13);

        bus.keycode = 8'h28; cyc();
        check("dying_ignores_key", st(), 32'd3);
        bus.keycode = 8'd0;
        tick(2);
        check("dying_t2_state", st(), 32'd3);
        check("dying_t2_gop",   32'(bus.game_over_pulse), 32'd0);
        tick(1);
        check("go_state", st(), 32'd4);
        check("go_pulse", 32'(bus.game_over_pulse), 32'd1);
        check("go_best",  bs(), 32'd13);
        cyc();
        check("go_pulse_once", 32'(bus.game_over_pulse), 32'd0);

        // GAME_OVER ignores mode keys; restart holds Mode and survive_frames.
        bus.keycode = 8'd30; cyc();
        check("go_ignores_key", st(), 32'd4);
        bus.keycode = 8'h28; cyc();
        check("restart_state",   st(), 32'd0);
        check("restart_mode",    md(), 32'd2);
        check("restart_survive", sv(), 32'd13);

        // Run 2 at Mode 2: 20 frames sets a new best.
        bus.keycode = 8'd32; cyc();
        check("mode2_state",   st(), 32'd1);
        check("mode2_mode",    md(), 32'd2);
        check("mode2_survive", sv(), 32'd0);
        bus.keycode = 8'd0;
        tick(20);
        check("run2_survive", sv(), 32'd20);
        check("run2_lvlup",   32'(bus.level_up), 32'd0);
        bus.is_collision = 1'b1; cyc(); bus.is_collision = 1'b0;
        check("run2_dying", st(), 32'd3);
        tick(2);
        check("run2_death_cleared", st(), 32'd3);
        tick(1);
        check("run2_go_state", st(), 32'd4);
        check("run2_go_pulse", 32'(bus.game_over_pulse), 32'd1);
        check("run2_best",     bs(), 32'd20);

        // Run 3: 12 frames from Mode 0, best stays 20.
        bus.keycode = 8'h28; cyc();
        bus.keycode = 8'd30; cyc();
        check("run3_mode_start", md(), 32'd0);
        bus.keycode = 8'd0;
        tick(12);
        check("run3_mode",    md(), 32'd2);
        check("run3_survive", sv(), 32'd12);
        bus.is_collision = 1'b1; cyc(); bus.is_collision = 1'b0;
        tick(3);
        check("run3_go_state", st(), 32'd4);
        check("run3_best",     bs(), 32'd20);

        // Reset in DYING with a mode key held through it.
        bus.keycode = 8'h28; cyc();
        bus.keycode = 8'd31; cyc();
        check("run4_mode", md(), 32'd1);
        bus.keycode = 8'd0;
        tick(2);
        bus.is_collision = 1'b1; cyc(); bus.is_collision = 1'b0;
        tick(1);
        check("run4_dying", st(), 32'd3);
        rst = 1'b1; bus.keycode = 8'd31; cyc();
        check("midrst_state",   st(), 32'd0);
        check("midrst_best",    bs(), 32'd0);
        check("midrst_survive", sv(), 32'd0);
        check("midrst_mode",    md(), 32'd0);
        rst = 1'b0; cyc();
        check("held_key_press_state", st(), 32'd1);
        check("held_key_press_mode",  md(), 32'd1);
        bus.keycode = 8'd0; cyc(); cyc();
        check("held_key_final_state", st(), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
